l2_bank_arbiter: RTL and testbench
==================================

# l2_bank_arbiter

Round-robin arbiter sharing one L2 SRAM bank between `NumReq` requesters on the interleaved side of the L2 path. Each requester issues single-beat word requests on a valid/ready port. The block grants one request per cycle, drives the bank's SRAM port, and returns the read data or write acknowledgment to the winning requester after a fixed bank latency. One instance sits in front of each of the `NumL2` banks.

## Interface
- `NumReq`, 4: number of requesters; ≥1.
- `AddrWidth`, 32: byte-address width of requester ports.
- `DataWidth`, 64: bank word width in bits; power of two, ≥8.
- `BankAddrWidth`, 16: word-address width of the bank.
- `RspLatency`, 1: cycles from bank request to valid `bank_rdata_i`; ≥1.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_valid_i`  in  [NumReq]  request valid per requester.
- `req_ready_o`  out  [NumReq]  grant per requester; one-hot or zero.
- `req_addr_i`  in  [NumReq][AddrWidth]  byte address (already interleaved/scrambled).
- `req_we_i`  in  [NumReq]  1 = write, 0 = read.
- `req_wdata_i`  in  [NumReq][DataWidth]  write data.
- `req_be_i`  in  [NumReq][DataWidth/8]  byte enables.
- `rsp_valid_o`  out  [NumReq]  response valid; no backpressure.
- `rsp_rdata_o`  out  [DataWidth]  response data, shared by all requesters.
- `bank_req_o`  out  1  SRAM request.
- `bank_we_o`  out  1  SRAM write enable.
- `bank_addr_o`  out  [BankAddrWidth]  SRAM word address.
- `bank_wdata_o`  out  [DataWidth]  SRAM write data.
- `bank_be_o`  out  [DataWidth/8]  SRAM byte enables.
- `bank_rdata_i`  in  [DataWidth]  SRAM read data, valid `RspLatency` cycles after request.
- `perf_stall_o`  out  [NumReq][32]  per-requester stall counters (see Configuration).

## Operation
- Grant is combinational. The winner is the first requester with `req_valid_i` set, searching upward from `rr_ptr` and wrapping. `req_ready_o[winner]`=1; all other ready signals are 0.
- `bank_req_o` = OR of `req_valid_i`. `bank_we_o`, `bank_wdata_o`, and `bank_be_o` are muxed from the winner.
- `bank_addr_o` = `req_addr_i[winner][BankAddrWidth+$clog2(DataWidth/8)-1 : $clog2(DataWidth/8)]`. Upper address bits are ignored.
- When `bank_req_o` is 0, all bank outputs are driven to 0.
- `rr_ptr` has width `max(1,$clog2(NumReq))` and resets to 0. On every grant cycle, `rr_ptr` becomes `(winner+1) mod NumReq`; when `NumReq` is not a power of two, the value wraps explicitly from `NumReq-1` to 0. With no grant, `rr_ptr` holds.
- A response pipeline `RspLatency` stages deep carries {valid, one-hot winner}. It shifts every cycle and resets to all-zero.
- `rsp_valid_o` = one-hot of the last stage. Reads and writes both produce exactly one response.
- `rsp_rdata_o` = `bank_rdata_i`, passed through combinationally. It is meaningful only when some bit of `rsp_valid_o` is set; it is don't-care for write responses.
- Requesters must accept a response in the cycle it is presented.
- A requester may change its request after an unready cycle; there is no stability requirement.

## Timing
- Grant at cycle t produces the response at cycle t+RspLatency. Throughput is one request per cycle.
- Back-to-back grants to the same requester occur only when it is the sole valid requester.
- With all N requesters valid continuously, each is granted exactly once every N cycles.
- Values during reset (`rst_ni`=0), which also apply in the first cycle after release:
  - `rsp_valid_o`=0, `rr_ptr`=0, pipeline empty, `perf_stall_o`=0.
  - `req_ready_o` and `bank_*` still follow the combinational request inputs.
- Reset asserted mid-operation discards in-flight responses. No response is emitted for requests granted before reset.

## Configuration
- `L2_BANK_ARB_PERF_EN` defined:
  - Each `perf_stall_o[i]` is a 32-bit counter, reset 0.
  - It increments on every cycle where `req_valid_i[i]`=1 and `req_ready_o[i]`=0.
  - It saturates at 0xFFFF_FFFF.
- `L2_BANK_ARB_PERF_EN` undefined: `perf_stall_o` is tied to 0 and no counter flops are instantiated.

## Test plan
- Single read: req 2 reads addr 0x0000_0040, `RspLatency`=1 -> `req_ready_o`=4'b0100 in cycle t, `bank_addr_o`=0x0008, `bank_we_o`=0; `rsp_valid_o`=4'b0100 in cycle t+1 with `rsp_rdata_o`=`bank_rdata_i`.
- Full contention: all 4 valid for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3. With PERF_EN, `perf_stall_o` = {6,6,6,6} after 8 cycles.
- Pointer skip: `rr_ptr`=1 with only requesters 0 and 3 valid -> grant 3, then 0, then 3.
- Write ack: req 1 writes `be`=0x0F, data 0x1122334455667788, `RspLatency`=3 -> bank signals carry exactly those values; `rsp_valid_o`=4'b0010 exactly 3 cycles later, once.
- Reset mid-flight: grant at t, `rst_ni` low at t+1 (`RspLatency`=2) -> no `rsp_valid_o` pulse ever appears; `rr_ptr` is back to 0, so the next contention grants req 0 first.
- Saturation (PERF_EN; the bench forces the counter to 0xFFFF_FFFE): req 0 starved for 3 more cycles -> counter reads 0xFFFF_FFFF.

Source files
------------

// File: rtl/l2_bank_arbiter_if.sv
// Requester-side and bank-side signal bundle for one L2 bank arbiter.
// The slave modport is the arbiter's view; master is the requesters/SRAM view.
interface l2_bank_arbiter_if #(
  parameter int NumReq        = 4,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 64,
  parameter int BankAddrWidth = 16
);
  logic [NumReq-1:0]                    req_valid_i;
  logic [NumReq-1:0]                    req_ready_o;
  logic [NumReq-1:0][AddrWidth-1:0]     req_addr_i;
  logic [NumReq-1:0]                    req_we_i;
  logic [NumReq-1:0][DataWidth-1:0]     req_wdata_i;
  logic [NumReq-1:0][DataWidth/8-1:0]   req_be_i;
  logic [NumReq-1:0]                    rsp_valid_o;
  logic [DataWidth-1:0]                 rsp_rdata_o;
  logic                                 bank_req_o;
  logic                                 bank_we_o;
  logic [BankAddrWidth-1:0]             bank_addr_o;
  logic [DataWidth-1:0]                 bank_wdata_o;
  logic [DataWidth/8-1:0]               bank_be_o;
  logic [DataWidth-1:0]                 bank_rdata_i;
  logic [NumReq-1:0][31:0]              perf_stall_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i, bank_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, bank_req_o, bank_we_o,
           bank_addr_o, bank_wdata_o, bank_be_o, perf_stall_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i, bank_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, bank_req_o, bank_we_o,
           bank_addr_o, bank_wdata_o, bank_be_o, perf_stall_o
  );
endinterface

// File: rtl/l2_bank_arbiter.sv
// Round-robin arbiter for one L2 SRAM bank: combinational grant, response RspLatency cycles later,
// no response backpressure. Define L2_BANK_ARB_PERF_EN for saturating per-requester stall counters.
module l2_bank_arbiter #(
  parameter int NumReq        = 4,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 64,
  parameter int BankAddrWidth = 16,
  parameter int RspLatency    = 1
) (
  input logic               clk_i,
  input logic               rst_ni,
  l2_bank_arbiter_if.slave  bus
);
  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int OffW = $clog2(DataWidth / 8);

  logic [PtrW-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]                    winner;
  logic                               grant_vld;
  logic [NumReq-1:0]                  grant_oh;
  logic [RspLatency-1:0][NumReq-1:0]  rsp_pipe_q, rsp_pipe_d;
  logic                               unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr_i;

  // Search upward from the pointer with explicit wrap so non-power-of-two NumReq works.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!grant_vld && bus.req_valid_i[idx]) begin
        grant_vld = 1'b1;
        winner    = PtrW'(idx);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_vld) grant_oh[winner] = 1'b1;
  end

  assign bus.req_ready_o = grant_oh;

  always_comb begin
    bus.bank_req_o   = grant_vld;
    bus.bank_we_o    = 1'b0;
    bus.bank_addr_o  = '0;
    bus.bank_wdata_o = '0;
    bus.bank_be_o    = '0;
    if (grant_vld) begin
      bus.bank_we_o    = bus.req_we_i[winner];
      bus.bank_addr_o  = bus.req_addr_i[winner][BankAddrWidth+OffW-1:OffW];
      bus.bank_wdata_o = bus.req_wdata_i[winner];
      bus.bank_be_o    = bus.req_be_i[winner];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      if (winner == PtrW'(NumReq - 1)) rr_ptr_d = '0;
      else                             rr_ptr_d = winner + PtrW'(1);
    end
  end

  always_comb begin
    rsp_pipe_d    = '0;
    rsp_pipe_d[0] = grant_oh;
    for (int s = 1; s < RspLatency; s++) rsp_pipe_d[s] = rsp_pipe_q[s-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      rsp_pipe_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rsp_pipe_q <= rsp_pipe_d;
    end
  end

  assign bus.rsp_valid_o = rsp_pipe_q[RspLatency-1];
  assign bus.rsp_rdata_o = bus.bank_rdata_i;

`ifdef L2_BANK_ARB_PERF_EN
  logic [NumReq-1:0][31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    for (int i = 0; i < NumReq; i++) begin
      if (bus.req_valid_i[i] && !grant_oh[i] && (perf_q[i] != 32'hFFFF_FFFF))
        perf_d[i] = perf_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign bus.perf_stall_o = perf_q;
`else
  assign bus.perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_l2_bank_arbiter.sv
// Randomized + directed scoreboard bench for l2_bank_arbiter (4 requesters, RspLatency 2).
module tb_l2_bank_arbiter;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_bank_arbiter_if #(.NumReq(N), .AddrWidth(32), .DataWidth(64), .BankAddrWidth(16)) bus ();

  l2_bank_arbiter #(
    .NumReq(N), .AddrWidth(32), .DataWidth(64), .BankAddrWidth(16), .RspLatency(LAT)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    int           due;
    logic [N-1:0] oh;
    logic         we;
  } rsp_t;

  rsp_t        sb[$];
  int          cyc = 0;
  int          m_ptr = 0;
  logic [31:0] m_perf [N];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference arbitration: first valid requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    int           w;
    logic [N-1:0] oh;
    logic [31:0]  a;
    bus.bank_rdata_i = {$urandom, $urandom};
    #1;
    w  = pick(bus.req_valid_i, m_ptr);
    oh = '0;
    if (w >= 0) oh[w] = 1'b1;
    chk("req_ready", 64'(bus.req_ready_o), 64'(oh));
    chk("bank_req", 64'(bus.bank_req_o), 64'(w >= 0));
    if (w >= 0) begin
      a = bus.req_addr_i[w];
      chk("bank_we", 64'(bus.bank_we_o), 64'(bus.req_we_i[w]));
      chk("bank_addr", 64'(bus.bank_addr_o), 64'((a >> 3) & 32'hFFFF));
      chk("bank_wdata", bus.bank_wdata_o, bus.req_wdata_i[w]);
      chk("bank_be", 64'(bus.bank_be_o), 64'(bus.req_be_i[w]));
    end else begin
      chk("bank_idle", {bus.bank_wdata_o[62:0], bus.bank_we_o},
          64'(bus.bank_addr_o) | 64'(bus.bank_be_o));
    end
    for (int i = 0; i < N; i++) begin
`ifdef L2_BANK_ARB_PERF_EN
      chk($sformatf("perf_stall[%0d]", i), 64'(bus.perf_stall_o[i]), 64'(m_perf[i]));
`else
      chk($sformatf("perf_stall[%0d]", i), 64'(bus.perf_stall_o[i]), 64'd0);
`endif
    end
    if (rst_n) begin
      if (w >= 0) begin
        sb.push_back('{due: cyc + LAT, oh: oh, we: bus.req_we_i[w]});
        m_ptr = (w + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (bus.req_valid_i[i] && !oh[i] && m_perf[i] != 32'hFFFF_FFFF) m_perf[i]++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic we,
                         input logic [63:0] wdata, input logic [7:0] be);
    bus.req_valid_i[i] = 1'b1;
    bus.req_addr_i[i]  = addr;
    bus.req_we_i[i]    = we;
    bus.req_wdata_i[i] = wdata;
    bus.req_be_i[i]    = be;
  endtask

  task automatic rand_all();
    for (int i = 0; i < N; i++)
      set_req(i, $urandom, 1'($urandom), {$urandom, $urandom}, 8'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_perf[i] = '0;
  endtask

  // Monitor: responses are popped and compared independently of the stimulus thread.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rsp_valid_in_reset", 64'(bus.rsp_valid_o), 64'd0);
      end else if (bus.rsp_valid_o != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_spurious", 64'(bus.rsp_valid_o), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
          chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(e.oh));
          if (!e.we) chk("rsp_rdata", bus.rsp_rdata_o, bus.bank_rdata_i);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("rsp_missing", 64'(bus.rsp_valid_o), 64'(e.oh));
      end
    end
  end

  initial begin
    bus.req_valid_i  = '0;
    bus.req_addr_i   = '0;
    bus.req_we_i     = '0;
    bus.req_wdata_i  = '0;
    bus.req_be_i     = '0;
    bus.bank_rdata_i = '0;
    do_reset();
    @(negedge clk);
    step();
    rand_all();
    step();
    rst_n = 1'b1;

    // All four contend from reset: rotation 0,1,2,3,0,1,2,3.
    rand_all();
    for (int c = 0; c < 8; c++) step();
    bus.req_valid_i = '0;
    step();

    // Single read from requester 2 at byte address 0x40.
    set_req(2, 32'h0000_0040, 1'b0, 64'd0, 8'hFF);
    step();
    bus.req_valid_i = '0;
    for (int c = 0; c < LAT; c++) step();

    // Move pointer to 1, then only 0 and 3 contend: 3,0,3.
    set_req(0, $urandom, 1'b0, 64'd0, 8'hFF);
    step();
    set_req(3, $urandom, 1'b0, 64'd0, 8'hFF);
    for (int c = 0; c < 3; c++) step();
    bus.req_valid_i = '0;

    // Write acknowledgment from requester 1.
    set_req(1, 32'h0001_2348, 1'b1, 64'h1122_3344_5566_7788, 8'h0F);
    step();
    bus.req_valid_i = '0;
    for (int c = 0; c < LAT + 1; c++) step();

    // Reset while a response is in flight: it must never appear.
    set_req(1, $urandom, 1'b0, 64'd0, 8'hFF);
    step();
    bus.req_valid_i = '0;
    do_reset();
    step();
    step();
    rst_n = 1'b1;
    rand_all();
    step();
    bus.req_valid_i = '0;
    for (int c = 0; c < LAT; c++) step();

`ifdef L2_BANK_ARB_PERF_EN
    // Counter saturation on a starved requester.
    force dut.perf_q[0] = 32'hFFFF_FFFE;
    #0;
    release dut.perf_q[0];
    m_perf[0] = 32'hFFFF_FFFE;
    rand_all();
    for (int c = 0; c < 6; c++) step();
    bus.req_valid_i = '0;
    step();
`endif

    for (int c = 0; c < 2000; c++) begin
      rand_all();
      bus.req_valid_i = 4'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
      else rst_n = 1'b1;
      step();
    end
    rst_n = 1'b1;
    bus.req_valid_i = '0;
    for (int c = 0; c < LAT + 2; c++) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
